usb_rx_sequencer: RTL
=====================

Name: usb_rx_sequencer

Overview:
Control FSM for the USB full-speed receive path. It sits beside the NRZI decoder, edge detector, shift register and bit timer. It detects packet start and validates the SYNC byte. It strobes each received byte into the RX FIFO, detects a clean or malformed EOP, and flags errors. It also reports the packet length and a completion pulse to the protocol layer.

Parameters:
SYNC_BYTE, 8'h80, required value of the first received byte (LSB-first already reassembled)
MAX_BYTES, 64, maximum data bytes per packet after SYNC; range 1..255

Ports:
clk  input  1  system clock (96 MHz)
n_rst  input  1  asynchronous active-low reset
d_edge  input  1  one-cycle pulse: transition detected on the bus
eop  input  1  SE0 currently detected (level)
shift_enable  input  1  one-cycle strobe per bit period (bit sample point)
byte_received  input  1  one-cycle pulse: 8 bits shifted in, rcv_data valid this cycle
rcv_data  input  8  assembled byte from shift register
rcving  output  1  packet reception in progress
w_enable  output  1  one-cycle FIFO write strobe
r_error  output  1  sticky error flag for current/last packet
pkt_done  output  1  one-cycle pulse on error-free packet end
pkt_len  output  8  count of data bytes written for current/last packet

Behaviour:
- All outputs are registered (Moore, decoded from state/registers). An input sampled at rising edge N changes outputs after edge N.
- Reset (async, n_rst=0): state IDLE, rcving=0, w_enable=0, r_error=0, pkt_done=0, pkt_len=0, bit_cnt=0. Reset mid-packet aborts immediately with no FIFO write.
- Internal bit_cnt (3 bit): +1 on each shift_enable; cleared on byte_received, which takes priority when both are high in the same cycle.
- States:
  - IDLE: rcving=0. d_edge -> START; r_error, pkt_len and bit_cnt clear on that edge.
  - START: rcving=1. byte_received with rcv_data==SYNC_BYTE -> RX. byte_received with any other value -> ERR. eop&&shift_enable before byte_received -> ERR.
  - RX: rcving=1.
    - byte_received with pkt_len<MAX_BYTES -> STORE.
    - byte_received with pkt_len==MAX_BYTES -> ERR (overflow; byte not written).
    - eop&&shift_enable with bit_cnt==0 -> EOP_WAIT (clean end).
    - eop&&shift_enable with bit_cnt!=0 -> ERR (partial byte).
    - When byte_received and eop&&shift_enable occur together, byte_received wins.
  - STORE: single cycle; w_enable=1, pkt_len+1 -> RX unconditionally.
  - EOP_WAIT: rcving=1. Waits for d_edge (return to J) -> IDLE. pkt_done=1 on the IDLE entry cycle only, and only if r_error=0.
  - ERR: r_error=1 (sticky until next packet start), rcving=1, no writes. eop&&shift_enable -> ERR_WAIT.
  - ERR_WAIT: d_edge -> IDLE; pkt_done stays 0.
- pkt_len holds its final value in IDLE until the next d_edge. It never wraps, because overflow diverts to ERR.
- An empty packet (SYNC then immediate clean EOP) is legal: pkt_done=1, pkt_len=0.
- d_edge in any state other than IDLE, EOP_WAIT or ERR_WAIT is ignored.
- Maximum w_enable rate: one per byte (≥8 bit periods apart). w_enable never asserts in IDLE, START, EOP_WAIT, ERR or ERR_WAIT.

Test Plan:
- Reset mid-RX (after 2 bytes stored) -> all outputs 0 asynchronously; next d_edge starts fresh with pkt_len=0.
- d_edge, byte 8'h80, bytes 8'hA5, 8'h3C, then eop+shift_enable with bit_cnt=0, then d_edge:
  - exactly two w_enable pulses, each one cycle after its byte_received
  - pkt_len=2, pkt_done one cycle high, r_error=0, rcving returns 0.
- d_edge, first byte 8'h81 -> r_error=1 and stays 1, no w_enable. eop then d_edge -> IDLE with r_error still 1 and pkt_done=0. Next d_edge clears r_error.
- SYNC, one byte, 3 more shift_enable strobes, then eop+shift_enable -> ERR, r_error=1, pkt_len=1, no pkt_done.
- MAX_BYTES=2: SYNC plus 3 data bytes -> 2 w_enable pulses, third byte_received -> r_error=1, pkt_len=2.
- SYNC then immediate clean EOP and d_edge -> pkt_done=1, pkt_len=0, no w_enable.

Source files
------------

// File: rtl/usb_rx_sequencer.sv
// usb_rx_sequencer: control FSM for the USB full-speed receive path.
// Watches edge/EOP/bit-strobe/byte-strobe events from the datapath, checks
// the SYNC byte, strobes data bytes into the RX FIFO, classifies the packet
// end as clean or malformed and reports length plus a completion pulse.
//
// Handshake: there is no backpressure. byte_received and shift_enable are
// single-cycle pulses that are always accepted. w_enable is a single-cycle
// write strobe that the FIFO must accept. It is raised the cycle after the
// byte_received that carried the byte.
module usb_rx_sequencer #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic       pkt_done,
  output logic [7:0] pkt_len
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_RX       = 3'd2,
    S_STORE    = 3'd3,
    S_EOP_WAIT = 3'd4,
    S_ERR      = 3'd5,
    S_ERR_WAIT = 3'd6
  } state_t;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic       w_eop_bit;

  // An SE0 seen at a bit sample point is the only EOP event that counts.
  assign w_eop_bit = eop & shift_enable;

  // Bits within the current byte. A completed byte resets the count even
  // if its final strobe arrives in the same cycle. A new packet also starts
  // the count from zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_cnt <= 3'd0;
    end else if (byte_received) begin
      r_bit_cnt <= 3'd0;
    end else if (r_state == S_IDLE && d_edge) begin
      r_bit_cnt <= 3'd0;
    end else if (shift_enable) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // Packet sequencer. All outputs are registered next to the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      rcving   <= 1'b0;
      w_enable <= 1'b0;
      r_error  <= 1'b0;
      pkt_done <= 1'b0;
      pkt_len  <= 8'd0;
    end else begin
      w_enable <= 1'b0;
      pkt_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (d_edge) begin
            r_state <= S_START;
            rcving  <= 1'b1;
            r_error <= 1'b0;
            pkt_len <= 8'd0;
          end
        end
        S_START: begin
          if (byte_received) begin
            if (rcv_data == SYNC_BYTE) begin
              r_state <= S_RX;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end else if (w_eop_bit) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end
        end
        S_RX: begin
          // A byte completing in the same cycle as the EOP bit is handled
          // as a byte. The EOP is seen again on the next SE0 strobe.
          if (byte_received) begin
            if (pkt_len < MAX_LEN) begin
              r_state  <= S_STORE;
              w_enable <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end else if (w_eop_bit) begin
            if (r_bit_cnt == 3'd0) begin
              r_state <= S_EOP_WAIT;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
        S_STORE: begin
          pkt_len <= pkt_len + 8'd1;
          r_state <= S_RX;
        end
        S_EOP_WAIT: begin
          if (d_edge) begin
            r_state  <= S_IDLE;
            rcving   <= 1'b0;
            pkt_done <= ~r_error;
          end
        end
        S_ERR: begin
          if (w_eop_bit) begin
            r_state <= S_ERR_WAIT;
          end
        end
        S_ERR_WAIT: begin
          if (d_edge) begin
            r_state <= S_IDLE;
            rcving  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          rcving  <= 1'b0;
        end
      endcase
    end
  end

endmodule
